// File: rtl/qos_pkg.sv
// Shared types and constants for the QoS dequeue scheduler.
package qos_pkg;

  localparam int unsigned NUM_BUFFERS = 4;
  localparam int unsigned COUNT_W     = 12;

  // Default per-round dequeue credits, buffer 1 (index 0) first.
  localparam int unsigned DEF_WEIGHT0 = 4;
  localparam int unsigned DEF_WEIGHT1 = 3;
  localparam int unsigned DEF_WEIGHT2 = 2;
  localparam int unsigned DEF_WEIGHT3 = 1;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    REQ
  } state_e;

  typedef logic [1:0] buf_idx_t;

  function automatic logic [NUM_BUFFERS-1:0] idx_to_onehot(buf_idx_t idx);
    logic [NUM_BUFFERS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/qos_tick_timer.sv
// Free-running tick generator: one-cycle pulse every TICK_CYCLES cycles while enabled.
module qos_tick_timer #(
  parameter int unsigned TICK_CYCLES = 150000000
) (
  input  logic clock_50,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count while enabled, wrap at the terminal value; disabled holds at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == CntMax);

endmodule

// File: rtl/qos_scheduler.sv
// Weighted round-robin dequeue scheduler over four packet buffers.
// Optional per-buffer served counters are built when QOS_SCHED_STATS_EN is defined.
module qos_scheduler
  import qos_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 150000000,
  parameter int unsigned WEIGHT0     = DEF_WEIGHT0,
  parameter int unsigned WEIGHT1     = DEF_WEIGHT1,
  parameter int unsigned WEIGHT2     = DEF_WEIGHT2,
  parameter int unsigned WEIGHT3     = DEF_WEIGHT3,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                   clock_50,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_BUFFERS-1:0] buf_empty,
  input  logic                   pop_ack,
  output logic                   pop_req,
  output logic [1:0]             pop_sel,
  output logic [NUM_BUFFERS-1:0] last_served,
  output logic                   busy,
  output logic                   timeout_err
`ifdef QOS_SCHED_STATS_EN
  ,
  output logic [COUNT_W-1:0]     served_count0,
  output logic [COUNT_W-1:0]     served_count1,
  output logic [COUNT_W-1:0]     served_count2,
  output logic [COUNT_W-1:0]     served_count3
`endif
);

  localparam int unsigned WaitW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(ACK_TIMEOUT - 1);

  logic tick;

  qos_tick_timer #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_timer (
    .clock_50(clock_50),
    .reset   (reset),
    .enable  (enable),
    .tick    (tick)
  );

  logic [2:0] weight [NUM_BUFFERS];
  assign weight[0] = 3'(WEIGHT0);
  assign weight[1] = 3'(WEIGHT1);
  assign weight[2] = 3'(WEIGHT2);
  assign weight[3] = 3'(WEIGHT3);

  state_e                 state_q, state_d;
  logic [2:0]             credit_q [NUM_BUFFERS];
  logic [2:0]             credit_d [NUM_BUFFERS];
  buf_idx_t               ptr_q, ptr_d;
  buf_idx_t               pop_sel_q, pop_sel_d;
  logic [NUM_BUFFERS-1:0] last_served_q, last_served_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [WaitW-1:0]       wait_q, wait_d;
`ifdef QOS_SCHED_STATS_EN
  logic [COUNT_W-1:0]     served_q [NUM_BUFFERS];
  logic [COUNT_W-1:0]     served_d [NUM_BUFFERS];
`endif

  logic     cred_found, any_found, sel_valid;
  buf_idx_t cred_idx, first_idx, idx;
  logic     timed_out;

  // Candidate search: cyclic from ptr for credit, and fallback first non-empty from 0.
  always_comb begin
    cred_found = 1'b0;
    cred_idx   = '0;
    any_found  = 1'b0;
    first_idx  = '0;
    idx        = '0;
    for (int k = 0; k < NUM_BUFFERS; k++) begin
      idx = ptr_q + buf_idx_t'(k);
      if (!cred_found && !buf_empty[idx] && (credit_q[idx] != 3'd0)) begin
        cred_found = 1'b1;
        cred_idx   = idx;
      end
      if (!any_found && !buf_empty[k]) begin
        any_found = 1'b1;
        first_idx = buf_idx_t'(k);
      end
    end
    sel_valid = cred_found || any_found;
  end

  assign timed_out = (wait_q == WaitMax);

  // FSM state register.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state; ticks seen outside IDLE are simply dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tick && (buf_empty != '1)) state_d = SELECT;
      SELECT:  state_d = sel_valid ? REQ : IDLE;
      REQ:     if (pop_ack || timed_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    pop_req = (state_q == REQ);
    busy    = (state_q != IDLE);
  end

  // Datapath next-state: credit bookkeeping, selection latch, ack/timeout handling.
  always_comb begin
    credit_d      = credit_q;
    ptr_d         = ptr_q;
    pop_sel_d     = pop_sel_q;
    last_served_d = last_served_q;
    timeout_err_d = timeout_err_q;
    wait_d        = wait_q;
`ifdef QOS_SCHED_STATS_EN
    served_d      = served_q;
`endif
    unique case (state_q)
      SELECT: begin
        wait_d = '0;
        if (cred_found) begin
          credit_d[cred_idx] = credit_q[cred_idx] - 3'd1;
          ptr_d              = cred_idx;
          pop_sel_d          = cred_idx;
        end else if (any_found) begin
          // Round exhausted: start a fresh round from buffer 1.
          for (int i = 0; i < NUM_BUFFERS; i++) credit_d[i] = weight[i];
          credit_d[first_idx] = weight[first_idx] - 3'd1;
          ptr_d               = first_idx;
          pop_sel_d           = first_idx;
        end
      end
      REQ: begin
        if (pop_ack) begin
          last_served_d = idx_to_onehot(pop_sel_q);
`ifdef QOS_SCHED_STATS_EN
          if (served_q[pop_sel_q] != '1) begin
            served_d[pop_sel_q] = served_q[pop_sel_q] + COUNT_W'(1);
          end
`endif
        end else if (timed_out) begin
          // Spent credit is intentionally not refunded.
          timeout_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      for (int i = 0; i < NUM_BUFFERS; i++) credit_q[i] <= weight[i];
      ptr_q         <= '0;
      pop_sel_q     <= '0;
      last_served_q <= '0;
      timeout_err_q <= 1'b0;
      wait_q        <= '0;
`ifdef QOS_SCHED_STATS_EN
      for (int i = 0; i < NUM_BUFFERS; i++) served_q[i] <= '0;
`endif
    end else begin
      credit_q      <= credit_d;
      ptr_q         <= ptr_d;
      pop_sel_q     <= pop_sel_d;
      last_served_q <= last_served_d;
      timeout_err_q <= timeout_err_d;
      wait_q        <= wait_d;
`ifdef QOS_SCHED_STATS_EN
      served_q      <= served_d;
`endif
    end
  end

  assign pop_sel     = pop_sel_q;
  assign last_served = last_served_q;
  assign timeout_err = timeout_err_q;
`ifdef QOS_SCHED_STATS_EN
  assign served_count0 = served_q[0];
  assign served_count1 = served_q[1];
  assign served_count2 = served_q[2];
  assign served_count3 = served_q[3];
`endif

endmodule

// File: tb/tb_qos_scheduler.sv
// Directed self-checking bench for qos_scheduler (TICK_CYCLES=4, ACK_TIMEOUT=16).
module tb_qos_scheduler;

  logic       clock_50 = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] buf_empty = 4'b0000;
  logic       pop_ack = 1'b0;
  logic       pop_req;
  logic [1:0] pop_sel;
  logic [3:0] last_served;
  logic       busy;
  logic       timeout_err;
`ifdef QOS_SCHED_STATS_EN
  logic [11:0] served_count0, served_count1, served_count2, served_count3;
`endif

  int checks = 0;
  int passed = 0;

  qos_scheduler #(
    .TICK_CYCLES(4),
    .WEIGHT0    (4),
    .WEIGHT1    (3),
    .WEIGHT2    (2),
    .WEIGHT3    (1),
    .ACK_TIMEOUT(16)
  ) dut (
    .clock_50   (clock_50),
    .reset      (reset),
    .enable     (enable),
    .buf_empty  (buf_empty),
    .pop_ack    (pop_ack),
    .pop_req    (pop_req),
    .pop_sel    (pop_sel),
    .last_served(last_served),
    .busy       (busy),
    .timeout_err(timeout_err)
`ifdef QOS_SCHED_STATS_EN
    ,
    .served_count0(served_count0),
    .served_count1(served_count1),
    .served_count2(served_count2),
    .served_count3(served_count3)
`endif
  );

  always #5 clock_50 = ~clock_50;

  task automatic do_reset();
    @(negedge clock_50);
    reset = 1'b1;
    repeat (2) @(negedge clock_50);
    reset = 1'b0;
  endtask

  // Wait (bounded) for a request, then acknowledge it one cycle later.
  task automatic serve(output logic [1:0] sel, output bit ok);
    ok  = 1'b0;
    sel = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock_50);
      if (pop_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      sel = pop_sel;
      @(negedge clock_50);
      pop_ack = 1'b1;
      @(negedge clock_50);
      pop_ack = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pop_req !== 1'b0 || pop_sel !== 2'd0 || last_served !== 4'd0 || busy !== 1'b0 ||
        timeout_err !== 1'b0)
      $display("FAIL reset_state: req=%b sel=%0d last=%b busy=%b terr=%b, want all 0",
               pop_req, pop_sel, last_served, busy, timeout_err);
    else passed++;
`ifdef QOS_SCHED_STATS_EN
    checks++;
    if ({served_count0, served_count1, served_count2, served_count3} !== 48'd0)
      $display("FAIL reset_stats: got %0d %0d %0d %0d, want 0", served_count0, served_count1,
               served_count2, served_count3);
    else passed++;
`endif
  endtask

  task automatic test_latency();
    bit seen = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock_50);
      if (dut.tick) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) $display("FAIL latency_tick: no tick within 20 cycles, want one");
    else passed++;
    @(negedge clock_50);
    checks++;
    if (busy !== 1'b1 || pop_req !== 1'b0)
      $display("FAIL latency_n1: busy=%b req=%b, want busy=1 req=0", busy, pop_req);
    else passed++;
    @(negedge clock_50);
    checks++;
    if (pop_req !== 1'b1 || pop_sel !== 2'd0)
      $display("FAIL latency_n2: req=%b sel=%0d, want req=1 sel=0", pop_req, pop_sel);
    else passed++;
    @(negedge clock_50);
    pop_ack = 1'b1;
    @(negedge clock_50);
    pop_ack = 1'b0;
    checks++;
    if (pop_req !== 1'b0 || last_served !== 4'b0001 || busy !== 1'b0)
      $display("FAIL latency_ack: req=%b last=%b busy=%b, want 0/0001/0", pop_req,
               last_served, busy);
    else passed++;
  endtask

  task automatic test_round();
    logic [1:0] exp_seq [11];
    logic [1:0] sel;
    logic [3:0] exp_last;
    bit         ok;
    exp_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
    do_reset();
    buf_empty = 4'b0000;
    for (int n = 0; n < 11; n++) begin
      serve(sel, ok);
      exp_last = 4'b0001 << exp_seq[n];
      checks++;
      if (!ok || sel !== exp_seq[n])
        $display("FAIL round_sel[%0d]: ok=%b sel=%0d, want sel=%0d", n, ok, sel, exp_seq[n]);
      else passed++;
      checks++;
      if (pop_req !== 1'b0 || last_served !== exp_last)
        $display("FAIL round_last[%0d]: req=%b last=%b, want req=0 last=%b", n, pop_req,
                 last_served, exp_last);
      else passed++;
    end
  endtask

  task automatic test_skip_empty();
    logic [1:0] exp_seq [4];
    logic [1:0] sel;
    bit         ok;
    exp_seq = '{2'd1, 2'd1, 2'd1, 2'd2};
    do_reset();
    buf_empty = 4'b0001;
    for (int n = 0; n < 4; n++) begin
      serve(sel, ok);
      checks++;
      if (!ok || sel !== exp_seq[n])
        $display("FAIL skip_sel[%0d]: ok=%b sel=%0d, want sel=%0d", n, ok, sel, exp_seq[n]);
      else passed++;
    end
    checks++;
    if (dut.credit_q[0] !== 3'd4)
      $display("FAIL skip_credit0: got %0d, want 4", dut.credit_q[0]);
    else passed++;
    buf_empty = 4'b0000;
  endtask

  task automatic test_all_empty();
    int bad = 0;
    do_reset();
    buf_empty = 4'b1111;
    for (int i = 0; i < 30; i++) begin
      pop_ack = (i == 10);
      @(negedge clock_50);
      if (pop_req !== 1'b0 || busy !== 1'b0) bad++;
    end
    pop_ack = 1'b0;
    checks++;
    if (bad != 0) $display("FAIL all_empty_idle: %0d active cycles, want 0", bad);
    else passed++;
    checks++;
    if (last_served !== 4'b0000)
      $display("FAIL stray_ack: last=%b, want 0000", last_served);
    else passed++;
    buf_empty = 4'b0000;
  endtask

  task automatic test_timeout();
    int         cnt = 0;
    bit         seen = 1'b0;
    logic [1:0] sel;
    bit         ok;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clock_50);
      if (pop_req) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      cnt = 1;
      for (int i = 0; i < 40; i++) begin
        @(negedge clock_50);
        if (!pop_req) break;
        cnt++;
      end
    end
    checks++;
    if (cnt != 16) $display("FAIL timeout_len: req high %0d cycles, want 16", cnt);
    else passed++;
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL timeout_flag: terr=%b busy=%b, want terr=1 busy=0", timeout_err, busy);
    else passed++;
    serve(sel, ok);
    checks++;
    if (!ok || sel !== 2'd0 || timeout_err !== 1'b1)
      $display("FAIL timeout_sticky: ok=%b sel=%0d terr=%b, want sel=0 terr=1", ok, sel,
               timeout_err);
    else passed++;
  endtask

  task automatic test_reset_mid_req();
    logic [1:0] sel;
    bit         ok;
    bit         seen = 1'b0;
    serve(sel, ok);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock_50);
      if (pop_req) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || last_served === 4'b0000)
      $display("FAIL midreq_setup: seen=%b last=%b, want request and nonzero last", seen,
               last_served);
    else passed++;
    reset   = 1'b1;
    pop_ack = 1'b1;
    @(negedge clock_50);
    reset = 1'b0;
    checks++;
    if (pop_req !== 1'b0 || last_served !== 4'b0000 || timeout_err !== 1'b0)
      $display("FAIL midreq_reset: req=%b last=%b terr=%b, want 0/0000/0", pop_req,
               last_served, timeout_err);
    else passed++;
`ifdef QOS_SCHED_STATS_EN
    checks++;
    if ({served_count0, served_count1, served_count2, served_count3} !== 48'd0)
      $display("FAIL midreq_stats: got %0d %0d %0d %0d, want 0", served_count0, served_count1,
               served_count2, served_count3);
    else passed++;
`endif
    @(negedge clock_50);
    pop_ack = 1'b0;
    checks++;
    if (last_served !== 4'b0000 || busy !== 1'b0)
      $display("FAIL midreq_ack_ignored: last=%b busy=%b, want 0000/0", last_served, busy);
    else passed++;
  endtask

  task automatic test_enable_low();
    int         bad = 0;
    logic [1:0] sel;
    bit         ok;
    enable = 1'b0;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      @(negedge clock_50);
      if (busy !== 1'b0 || pop_req !== 1'b0 || dut.tick !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL enable_low: %0d active cycles, want 0", bad);
    else passed++;
    enable = 1'b1;
    serve(sel, ok);
    checks++;
    if (!ok || sel !== 2'd0) $display("FAIL enable_resume: ok=%b sel=%0d, want sel=0", ok, sel);
    else passed++;
  endtask

`ifdef QOS_SCHED_STATS_EN
  task automatic test_stats();
    logic [1:0] sel;
    bit         ok;
    int         fails = 0;
    do_reset();
    buf_empty = 4'b1110;
    for (int n = 0; n < 4100; n++) begin
      serve(sel, ok);
      if (!ok) begin
        fails++;
        break;
      end
      if (n == 4) begin
        checks++;
        if (served_count0 !== 12'd5)
          $display("FAIL stats_count5: got %0d, want 5", served_count0);
        else passed++;
      end
    end
    checks++;
    if (fails != 0 || served_count0 !== 12'd4095)
      $display("FAIL stats_saturate: stalled=%0d count0=%0d, want 0/4095", fails,
               served_count0);
    else passed++;
    checks++;
    if (served_count1 !== 12'd0 || served_count2 !== 12'd0 || served_count3 !== 12'd0)
      $display("FAIL stats_others: got %0d %0d %0d, want 0", served_count1, served_count2,
               served_count3);
    else passed++;
    buf_empty = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_round();
    test_skip_empty();
    test_all_empty();
    test_timeout();
    test_reset_mid_req();
    test_enable_low();
`ifdef QOS_SCHED_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/qos_scheduler.md
QOS_SCHEDULER -- requirements
Module: qos_scheduler

Interface
REQ-001 Parameter TICK_CYCLES, default 150000000, clock_50 cycles between dequeue opportunities (3 s at 50 MHz).
REQ-002 Parameter WEIGHT0..WEIGHT3, default 4,3,2,1, dequeue credits per round for buffer 1..4 (buffer 1 highest priority); each 1..7.
REQ-003 Parameter ACK_TIMEOUT, default 16, cycles pop_req may wait for pop_ack.
REQ-004 clock_50  in  1  sole clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 enable  in  1  scheduling permitted (driven from start).
REQ-007 buf_empty  in  4  bit i high = buffer i+1 holds no packet.
REQ-008 pop_ack  in  1  one-cycle pulse from buffer container: head packet of pop_sel removed.
REQ-009 pop_req  out  1  dequeue request, held until ack or timeout.
REQ-010 pop_sel  out  2  index (0..3) of buffer being dequeued; stable while pop_req high.
REQ-011 last_served  out  4  one-hot buffer of last acknowledged dequeue; 0 = none yet.
REQ-012 busy  out  1  high when state is not IDLE.
REQ-013 timeout_err  out  1  sticky, set on ack timeout.
REQ-014 served_count0..3  out  12 each  per-buffer acknowledged dequeues (only with QOS_SCHED_STATS_EN).

Function
REQ-015 Tick counter counts 0..TICK_CYCLES-1 while enable high, wraps to 0; tick pulses on the cycle the counter equals TICK_CYCLES-1; enable low holds counter at 0, no ticks.
REQ-016 States IDLE, SELECT, REQ; IDLE->SELECT on tick when buf_empty != 4'b1111; tick with all empty: stay IDLE, no credit change.
REQ-017 Ticks arriving in SELECT or REQ are discarded, not queued.
REQ-018 SELECT (one cycle): choose first buffer, cyclic from ptr, that is non-empty with credit>0; if none, reload all credits to weights and choose first non-empty from index 0.
REQ-019 Chosen buffer: credit decremented by 1, ptr set to it, pop_sel latched; SELECT->REQ.
REQ-020 Empty buffers are skipped; their credits are retained.
REQ-021 Latency: tick at cycle N -> pop_req high at cycle N+2.
REQ-022 REQ: pop_req high; on pop_ack, pop_req low next cycle, last_served = onehot(pop_sel), -> IDLE.
REQ-023 No pop_ack within ACK_TIMEOUT cycles of pop_req rising: pop_req low, timeout_err set, credit not restored, -> IDLE.
REQ-024 pop_ack outside REQ ignored; pop_ack and timeout on same cycle: ack wins.
REQ-025 enable falling during SELECT/REQ: current transaction completes; no new ticks.

Reset
REQ-026 reset forces IDLE, tick counter 0, ptr 0, credits = weights, pop_req 0, pop_sel 0, last_served 0, busy 0, timeout_err 0, served_count* 0; applies mid-REQ (pop_req low next cycle, pending ack ignored).

Configuration
REQ-027 Macro QOS_SCHED_STATS_EN defined: served_count0..3 present, increment on each acknowledged dequeue of that buffer, saturate at 4095.
REQ-028 Macro undefined: served_count ports and counters absent; all other behaviour identical.

Structure
REQ-029 Package qos_pkg holds NUM_BUFFERS=4, state enum (IDLE, SELECT, REQ), 2-bit buffer index type, 12-bit count width, default weight constants.
REQ-030 Sub-module qos_tick_timer implements REQ-015 (inputs clock_50, reset, enable; output tick).

Verification (TICK_CYCLES=4, ACK_TIMEOUT=16, ack one cycle after pop_req)
REQ-031 All buffers non-empty, enable high, 10 ticks -> pop_sel sequence 0,0,0,0,1,1,1,2,2,3; 11th tick -> 0.
REQ-032 buf_empty=4'b0001, 4 ticks -> pop_sel 1,1,1,2; buffer 0 credit still 4.
REQ-033 buf_empty=4'b1111, ticks -> pop_req never high, busy stays 0.
REQ-034 pop_ack withheld -> pop_req drops after 16 cycles, timeout_err=1 until reset.
REQ-035 reset asserted while pop_req high -> next cycle pop_req=0, last_served=0, served_count*=0.
REQ-036 STATS build, buffer 0 served 4100 times -> served_count0=4095; others unchanged.
